// File: rtl/axi_master_wr.sv
// ---------------------------------------------------------------------------
// axi_master_wr
//   Single-outstanding AXI write master. A user command (address, length,
//   size, burst type) is turned into one AW transfer, followed by len+1 W
//   beats streamed straight from the user data port, and finally a B
//   response that is reported back to the user as a one-cycle done pulse.
//
// Optional feature (compile-time macro AXI_MASTER_WR_BTIMEOUT_EN):
//   When defined, the RESP state gives up after TIMEOUT_CYCLES cycles
//   without b_valid and reports done with done_resp = 2'b10 (SLVERR).
//   When undefined, RESP waits for b_valid indefinitely.
//
// Ports
//   aclk, areset                 clock (rising edge), async active-high reset
//   cmd_valid/cmd_ready          user command handshake
//   cmd_addr/len/size/burst      command fields (len = beats-1)
//   wd_valid/wd_ready            user write data handshake
//   wd_data/wd_strb              user write data and byte strobes
//   done, done_resp              completion pulse and response code
//   aw_*                         AXI write address channel
//   w_*                          AXI write data channel
//   b_valid/b_ready/b_resp       AXI write response channel
// ---------------------------------------------------------------------------
module axi_master_wr #(
  parameter int ADDR_BITS      = 32,
  parameter int DATA_BITS      = 32,
  parameter int LEN_BITS       = 8,
  parameter int SIZE_BITS      = 3,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                   aclk,
  input  logic                   areset,
  // user command
  input  logic                   cmd_valid,
  output logic                   cmd_ready,
  input  logic [ADDR_BITS-1:0]   cmd_addr,
  input  logic [LEN_BITS-1:0]    cmd_len,
  input  logic [SIZE_BITS-1:0]   cmd_size,
  input  logic [1:0]             cmd_burst,
  // user write data
  input  logic                   wd_valid,
  output logic                   wd_ready,
  input  logic [DATA_BITS-1:0]   wd_data,
  input  logic [DATA_BITS/8-1:0] wd_strb,
  // completion
  output logic                   done,
  output logic [1:0]             done_resp,
  // AXI write address channel
  output logic                   aw_valid,
  input  logic                   aw_ready,
  output logic [ADDR_BITS-1:0]   aw_addr,
  output logic [LEN_BITS-1:0]    aw_len,
  output logic [SIZE_BITS-1:0]   aw_size,
  output logic [1:0]             aw_burst,
  output logic [3:0]             aw_cache,
  // AXI write data channel
  output logic                   w_valid,
  input  logic                   w_ready,
  output logic [DATA_BITS-1:0]   w_data,
  output logic [DATA_BITS/8-1:0] w_strb,
  output logic                   w_last,
  // AXI write response channel
  input  logic                   b_valid,
  output logic                   b_ready,
  input  logic [1:0]             b_resp
);

  localparam int STRB_BITS = DATA_BITS / 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_ADDR = 2'b01,
    ST_DATA = 2'b10,
    ST_RESP = 2'b11
  } state_t;

  state_t                 state_r;
  state_t                 state_nxt_s;

  logic [ADDR_BITS-1:0]   addr_r;
  logic [LEN_BITS-1:0]    len_r;
  logic [SIZE_BITS-1:0]   size_r;
  logic [1:0]             burst_r;
  logic [LEN_BITS-1:0]    beat_cnt_r;

  logic                   cmd_ready_r;
  logic                   aw_valid_r;
  logic                   b_ready_r;
  logic                   done_r;
  logic [1:0]             done_resp_r;

  logic                   in_data_s;
  logic                   cmd_hs_s;
  logic                   aw_hs_s;
  logic                   w_hs_s;
  logic                   last_beat_s;
  logic                   b_hs_s;
  logic                   tmo_hit_s;
  logic                   done_s;
  logic [1:0]             resp_s;

  // Handshake and beat-position decode
  assign in_data_s   = (state_r == ST_DATA);
  assign cmd_hs_s    = cmd_valid & cmd_ready_r;
  assign aw_hs_s     = aw_valid_r & aw_ready;
  assign last_beat_s = (beat_cnt_r == len_r);
  assign w_hs_s      = in_data_s & wd_valid & w_ready;
  assign b_hs_s      = b_ready_r & b_valid;

  // W channel is a pass-through of the user stream, opened only in DATA,
  // so no beat can leak out before the AW handshake has completed.
  assign w_valid  = in_data_s & wd_valid;
  assign wd_ready = in_data_s & w_ready;
  assign w_data   = in_data_s ? wd_data : {DATA_BITS{1'b0}};
  assign w_strb   = in_data_s ? wd_strb : {STRB_BITS{1'b0}};
  assign w_last   = in_data_s & last_beat_s;

  // Registered control outputs and captured AW fields
  assign cmd_ready = cmd_ready_r;
  assign aw_valid  = aw_valid_r;
  assign aw_addr   = addr_r;
  assign aw_len    = len_r;
  assign aw_size   = size_r;
  assign aw_burst  = burst_r;
  assign aw_cache  = 4'b0011;
  assign b_ready   = b_ready_r;
  assign done      = done_r;
  assign done_resp = done_resp_r;

`ifdef AXI_MASTER_WR_BTIMEOUT_EN
  localparam int TMO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

  logic [TMO_W-1:0] tmo_cnt_r;

  assign tmo_hit_s = (state_r == ST_RESP) & (tmo_cnt_r == TMO_LAST);

  // Counts cycles spent in RESP; held at zero outside RESP so every entry starts fresh
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      tmo_cnt_r <= {TMO_W{1'b0}};
    end else if (state_r != ST_RESP) begin
      tmo_cnt_r <= {TMO_W{1'b0}};
    end else if (!tmo_hit_s) begin
      tmo_cnt_r <= tmo_cnt_r + TMO_W'(1);
    end else begin
      tmo_cnt_r <= tmo_cnt_r;
    end
  end
`else
  assign tmo_hit_s = 1'b0;
`endif

  // Next-state and completion decode
  always_comb begin
    state_nxt_s = state_r;
    done_s      = 1'b0;
    resp_s      = 2'b00;
    case (state_r)
      ST_IDLE: begin
        if (cmd_hs_s) begin
          state_nxt_s = ST_ADDR;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_ADDR: begin
        if (aw_hs_s) begin
          state_nxt_s = ST_DATA;
        end else begin
          state_nxt_s = ST_ADDR;
        end
      end
      ST_DATA: begin
        if (w_hs_s && last_beat_s) begin
          state_nxt_s = ST_RESP;
        end else begin
          state_nxt_s = ST_DATA;
        end
      end
      ST_RESP: begin
        if (b_hs_s) begin
          state_nxt_s = ST_IDLE;
          done_s      = 1'b1;
          resp_s      = b_resp;
        end else if (tmo_hit_s) begin
          // slave never answered: report SLVERR and release the bus
          state_nxt_s = ST_IDLE;
          done_s      = 1'b1;
          resp_s      = 2'b10;
        end else begin
          state_nxt_s = ST_RESP;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // State register plus control outputs registered from the next state,
  // so cmd_ready/aw_valid/b_ready line up exactly with the state they belong to
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      state_r     <= ST_IDLE;
      cmd_ready_r <= 1'b0;
      aw_valid_r  <= 1'b0;
      b_ready_r   <= 1'b0;
      done_r      <= 1'b0;
      done_resp_r <= 2'b00;
    end else begin
      state_r     <= state_nxt_s;
      cmd_ready_r <= (state_nxt_s == ST_IDLE);
      aw_valid_r  <= (state_nxt_s == ST_ADDR);
      b_ready_r   <= (state_nxt_s == ST_RESP);
      done_r      <= done_s;
      if (done_s) begin
        done_resp_r <= resp_s;
      end else begin
        done_resp_r <= done_resp_r;
      end
    end
  end

  // Command capture on accept; fields then stay stable through the burst
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      addr_r  <= {ADDR_BITS{1'b0}};
      len_r   <= {LEN_BITS{1'b0}};
      size_r  <= {SIZE_BITS{1'b0}};
      burst_r <= 2'b00;
    end else if (cmd_hs_s) begin
      addr_r  <= cmd_addr;
      len_r   <= cmd_len;
      size_r  <= cmd_size;
      burst_r <= cmd_burst;
    end else begin
      addr_r  <= addr_r;
      len_r   <= len_r;
      size_r  <= size_r;
      burst_r <= burst_r;
    end
  end

  // Beat counter: not advanced on the final beat, so len = all-ones never wraps
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      beat_cnt_r <= {LEN_BITS{1'b0}};
    end else if (aw_hs_s) begin
      beat_cnt_r <= {LEN_BITS{1'b0}};
    end else if (w_hs_s && !last_beat_s) begin
      beat_cnt_r <= beat_cnt_r + LEN_BITS'(1);
    end else begin
      beat_cnt_r <= beat_cnt_r;
    end
  end

endmodule

// File: tb/tb_axi_master_wr.sv
// ---------------------------------------------------------------------------
// tb_axi_master_wr
//   Directed bench for axi_master_wr. A transaction-level model (queues of
//   expected commands and beats plus a few phase flags) is checked against
//   the DUT on every falling edge; directed bursts add literal expectations.
//   Define AXI_MASTER_WR_BTIMEOUT_EN to build with the B-channel timeout.
// ---------------------------------------------------------------------------
module tb_axi_master_wr;

`ifdef AXI_MASTER_WR_BTIMEOUT_EN
  localparam int TMO = 16;
`else
  localparam int TMO = 256;
`endif

  logic        aclk = 1'b0;
  logic        areset;
  logic        cmd_valid, cmd_ready;
  logic [31:0] cmd_addr;
  logic [7:0]  cmd_len;
  logic [2:0]  cmd_size;
  logic [1:0]  cmd_burst;
  logic        wd_valid, wd_ready;
  logic [31:0] wd_data;
  logic [3:0]  wd_strb;
  logic        done;
  logic [1:0]  done_resp;
  logic        aw_valid, aw_ready;
  logic [31:0] aw_addr;
  logic [7:0]  aw_len;
  logic [2:0]  aw_size;
  logic [1:0]  aw_burst;
  logic [3:0]  aw_cache;
  logic        w_valid, w_ready;
  logic [31:0] w_data;
  logic [3:0]  w_strb;
  logic        w_last;
  logic        b_valid, b_ready;
  logic [1:0]  b_resp;

  always #5 aclk = ~aclk;

  axi_master_wr #(
    .ADDR_BITS(32), .DATA_BITS(32), .LEN_BITS(8), .SIZE_BITS(3), .TIMEOUT_CYCLES(TMO)
  ) dut (
    .aclk(aclk), .areset(areset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr),
    .cmd_len(cmd_len), .cmd_size(cmd_size), .cmd_burst(cmd_burst),
    .wd_valid(wd_valid), .wd_ready(wd_ready), .wd_data(wd_data), .wd_strb(wd_strb),
    .done(done), .done_resp(done_resp),
    .aw_valid(aw_valid), .aw_ready(aw_ready), .aw_addr(aw_addr), .aw_len(aw_len),
    .aw_size(aw_size), .aw_burst(aw_burst), .aw_cache(aw_cache),
    .w_valid(w_valid), .w_ready(w_ready), .w_data(w_data), .w_strb(w_strb), .w_last(w_last),
    .b_valid(b_valid), .b_ready(b_ready), .b_resp(b_resp)
  );

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  typedef struct { logic [31:0] addr; int len; logic [2:0] size; logic [1:0] burst; } cmd_t;
  typedef struct { logic [31:0] data; logic [3:0] strb; } beat_t;

  cmd_t  cmd_q[$];
  beat_t beat_q[$];
  logic [31:0] dat [0:255];
  logic [3:0]  stb [0:255];

  // model phase flags: accepted-not-finished, awaiting AW, streaming W, awaiting B
  bit m_first, m_busy, m_aw, m_data, m_resp, m_exp_done;
  logic [1:0] m_exp_resp;
  int m_beats, m_rc;
  int mon_beats, mon_lasts, mon_dones;

  // Model/compare process; phases are evaluated last-to-first so a phase
  // entered this cycle is only checked from the next cycle on.
  always @(negedge aclk) begin
    if (areset) begin
      chk("rst_cmd_ready", cmd_ready, 0);
      chk("rst_aw_valid", aw_valid, 0);
      chk("rst_b_ready", b_ready, 0);
      chk("rst_done", done, 0);
      chk("rst_done_resp", done_resp, 0);
      chk("rst_w_valid", w_valid, 0);
      chk("rst_wd_ready", wd_ready, 0);
      chk("rst_aw_addr", aw_addr, 0);
      chk("rst_aw_len", aw_len, 0);
      cmd_q.delete(); beat_q.delete();
      m_first = 1; m_busy = 0; m_aw = 0; m_data = 0; m_resp = 0;
      m_exp_done = 0; m_beats = 0; m_rc = 0;
    end else begin
      chk("done", done, m_exp_done);
      if (m_exp_done) chk("done_resp", done_resp, m_exp_resp);
      if (done) mon_dones++;
      m_exp_done = 0;
      chk("cmd_ready", cmd_ready, !m_busy && !m_first);
      m_first = 0;

      chk("b_ready", b_ready, m_resp);
      if (m_resp) begin
        if (b_valid) begin
          m_exp_done = 1; m_exp_resp = b_resp; m_resp = 0; m_busy = 0;
          if (cmd_q.size() > 0) cmd_q.delete(0);
        end
`ifdef AXI_MASTER_WR_BTIMEOUT_EN
        else if (m_rc == TMO - 1) begin
          m_exp_done = 1; m_exp_resp = 2'b10; m_resp = 0; m_busy = 0;
          if (cmd_q.size() > 0) cmd_q.delete(0);
        end else m_rc++;
`endif
      end

      chk("w_valid", w_valid, m_data && wd_valid);
      chk("wd_ready", wd_ready, m_data && w_ready);
      if (w_valid && cmd_q.size() > 0) begin
        chk("w_last", w_last, m_beats == cmd_q[0].len);
        if (w_ready) begin
          if (beat_q.size() == 0) chk("beat_underflow", 1, 0);
          else begin
            chk("w_data", w_data, beat_q[0].data);
            chk("w_strb", w_strb, beat_q[0].strb);
            beat_q.delete(0);
          end
          mon_beats++;
          if (w_last) mon_lasts++;
          if (m_beats == cmd_q[0].len) begin m_data = 0; m_resp = 1; m_rc = 0; end
          else m_beats++;
        end
      end

      chk("aw_valid", aw_valid, m_aw);
      if (aw_valid && cmd_q.size() > 0) begin
        chk("aw_addr", aw_addr, cmd_q[0].addr);
        chk("aw_len", aw_len, cmd_q[0].len);
        chk("aw_size", aw_size, cmd_q[0].size);
        chk("aw_burst", aw_burst, cmd_q[0].burst);
        chk("aw_cache", aw_cache, 4'b0011);
        if (aw_ready) begin m_aw = 0; m_data = 1; m_beats = 0; end
      end
      if (cmd_valid && cmd_ready) begin m_busy = 1; m_aw = 1; end
    end
  end

  task automatic tick();
    @(posedge aclk); #1;
  endtask

  // wr_mode: 0 = always ready, 1 = w_ready toggles 1/0, 2 = gaps on both sides
  task automatic burst(input logic [31:0] addr, input int len, input int aw_wait,
                       input int wr_mode, input logic [1:0] resp, input int b_wait,
                       input bit b_hold, input int abort_beat, input bit no_b);
    cmd_t c; beat_t b; int sent, cyc, guard; bit hs;
    c.addr = addr; c.len = len; c.size = 3'd2; c.burst = 2'b01;
    cmd_q.push_back(c);
    for (int i = 0; i <= len; i++) begin
      dat[i] = addr ^ (32'(i) * 32'h0101_0101) ^ 32'hA500_005A;
      stb[i] = (i % 3 == 2) ? 4'b0101 : 4'b1111;
      b.data = dat[i]; b.strb = stb[i];
      beat_q.push_back(b);
    end
    cmd_addr = addr; cmd_len = 8'(len); cmd_size = 3'd2; cmd_burst = 2'b01;
    b_resp = resp; b_valid = b_hold;
    aw_ready = (aw_wait == 0); w_ready = 1'b1;
    wd_valid = 1'b1; wd_data = dat[0]; wd_strb = stb[0];
    cmd_valid = 1'b1;
    guard = 0;
    while (!cmd_ready && guard < 20) begin tick(); guard++; end
    if (guard >= 20) chk("cmd_ready_wait", 0, 1);
    tick();
    cmd_valid = 1'b0;
    chk("aw_valid_after_accept", aw_valid, 1);
    for (int k = 0; k < aw_wait; k++) begin
      chk("aw_addr_hold", aw_addr, addr);
      chk("aw_len_hold", aw_len, len);
      chk("w_valid_before_aw", w_valid, 0);
      tick();
    end
    aw_ready = 1'b1;
    tick();
    aw_ready = 1'b0;
    sent = 0; cyc = 0; guard = 0;
    while (sent <= len && guard < 2000) begin
      wd_valid = (wr_mode == 2) ? (cyc % 3 != 1) : 1'b1;
      w_ready  = (wr_mode == 1) ? (cyc % 2 == 0) : (wr_mode == 2) ? (cyc % 4 != 3) : 1'b1;
      wd_data = dat[sent]; wd_strb = stb[sent];
      #1;
      hs = wd_valid && wd_ready;
      if (abort_beat > 0 && sent == abort_beat - 1) begin
        areset = 1'b1;
        return;
      end
      @(posedge aclk); #1;
      if (hs) sent++;
      cyc++; guard++;
    end
    if (guard >= 2000) chk("w_beats_wait", 0, 1);
    // keep user data and w_ready active while waiting for B: must not leak out
    wd_valid = 1'b1; w_ready = 1'b1;
    guard = 0;
    while (!b_ready && guard < 20) begin tick(); guard++; end
    if (guard >= 20) chk("b_ready_wait", 0, 1);
    if (no_b) begin
      guard = 0;
      while (!done && guard < 100) begin tick(); guard++; end
      chk("tmo_latency", guard, 16);
      chk("tmo_done_resp", done_resp, 2'b10);
      chk("tmo_b_ready_drop", b_ready, 0);
      chk("tmo_cmd_ready", cmd_ready, 1);
    end else begin
      repeat (b_wait) tick();
      b_valid = 1'b1;
      tick();
      b_valid = 1'b0;
      chk("done_lit", done, 1);
      chk("done_resp_lit", done_resp, resp);
      chk("cmd_ready_after_done", cmd_ready, 1);
      chk("b_ready_after_done", b_ready, 0);
    end
    wd_valid = 1'b0; w_ready = 1'b0;
    tick();
    chk("done_one_cycle", done, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    areset = 1'b1; cmd_valid = 1'b0; cmd_addr = 32'h0; cmd_len = 8'h0;
    cmd_size = 3'd0; cmd_burst = 2'b00; wd_valid = 1'b0; wd_data = 32'h0;
    wd_strb = 4'h0; aw_ready = 1'b0; w_ready = 1'b0; b_valid = 1'b0; b_resp = 2'b00;
    repeat (3) @(posedge aclk);
    #1;
    chk("cmd_ready_in_reset", cmd_ready, 0);
    areset = 1'b0;
    #1;
    chk("cmd_ready_before_edge", cmd_ready, 0);
    tick();
    chk("cmd_ready_first_edge", cmd_ready, 1);

    // single beat, b_valid held high from the start (ignored until RESP)
    mon_beats = 0; mon_lasts = 0;
    burst(32'h0000_0040, 0, 0, 0, 2'b00, 0, 1'b1, 0, 1'b0);
    chk("single_beats", mon_beats, 1);
    chk("single_lasts", mon_lasts, 1);

    // len=3 with w_ready toggling
    mon_beats = 0; mon_lasts = 0;
    burst(32'h0000_1000, 3, 0, 1, 2'b01, 0, 1'b0, 0, 1'b0);
    chk("len3_beats", mon_beats, 4);
    chk("len3_lasts", mon_lasts, 1);

    // aw_ready held low for 5 cycles
    burst(32'h0000_2000, 1, 5, 0, 2'b00, 2, 1'b0, 0, 1'b0);

    // SLVERR response after gaps and delayed b_valid
    burst(32'h0000_3000, 2, 0, 2, 2'b10, 3, 1'b0, 0, 1'b0);

    // longest burst: 256 beats, counter must not wrap
    mon_beats = 0; mon_lasts = 0;
    burst(32'h0000_4000, 255, 0, 0, 2'b00, 0, 1'b0, 0, 1'b0);
    chk("len255_beats", mon_beats, 256);
    chk("len255_lasts", mon_lasts, 1);

    // reset during beat 2 of a len=7 burst
    mon_dones = 0;
    burst(32'h0000_5000, 7, 0, 0, 2'b00, 0, 1'b0, 2, 1'b0);
    #1;
    chk("abort_w_valid", w_valid, 0);
    chk("abort_wd_ready", wd_ready, 0);
    chk("abort_aw_valid", aw_valid, 0);
    chk("abort_cmd_ready", cmd_ready, 0);
    chk("abort_done", done, 0);
    wd_valid = 1'b0; w_ready = 1'b0;
    tick(); tick();
    areset = 1'b0;
    tick();
    chk("abort_cmd_ready_release", cmd_ready, 1);
    tick();
    chk("abort_no_done", mon_dones, 0);
    burst(32'h0000_6000, 0, 1, 0, 2'b11, 1, 1'b0, 0, 1'b0);

`ifdef AXI_MASTER_WR_BTIMEOUT_EN
    burst(32'h0000_7000, 1, 0, 0, 2'b00, 0, 1'b0, 0, 1'b1);
`else
    // no timeout build: a very long B wait still completes normally
    burst(32'h0000_7000, 1, 0, 0, 2'b01, 300, 1'b0, 0, 1'b0);
`endif

    repeat (3) tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
